// File: rtl/mpu_rx_unpack.sv
// Unpacks the 14-byte MPU-6050 burst (0x3B..0x48) into seven signed words,
// committing them atomically and flagging short, overrun, NACKed or stalled bursts.
module mpu_rx_unpack #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_start,
  input  logic        rd_now,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        rx_done,
  input  logic        ack_err,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        sample_valid,
  output logic        busy,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [15:0] sample_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  localparam logic [2:0] CODE_NONE    = 3'd0;
  localparam logic [2:0] CODE_SHORT   = 3'd1;
  localparam logic [2:0] CODE_OVERRUN = 3'd2;
  localparam logic [2:0] CODE_NACK    = 3'd3;
  localparam logic [2:0] CODE_TMO     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COLLECT   = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_COMMIT    = 3'd3,
    S_ERR       = 3'd4
  } state_t;

  state_t           state_r;
  logic             en_start_d_r;
  logic [3:0]       idx_r;
  logic [TMO_W-1:0] tmo_r;
  logic [7:0]       shadow_r [14];
  logic [7:0]       shadow_s [14];
  logic [15:0]      word_s   [7];
  logic [15:0]      word_r   [7];
  logic             sample_valid_r;
  logic             err_r;
  logic [2:0]       err_code_r;
  logic [15:0]      cnt_r;
  logic             busy_r;
  logic             start_s;
  logic             last_byte_s;
  logic             tmo_hit_s;
  logic [2:0]       fault_s;
  logic             commit_s;

  assign start_s     = en_start & ~en_start_d_r;
  assign last_byte_s = rx_valid && (idx_r == 4'd13);
  assign tmo_hit_s   = (tmo_r == TMO_LAST);

  // Shadow including the byte arriving this cycle, so a final byte coincident with rx_done commits.
  always_comb begin
    shadow_s = shadow_r;
    if ((state_r == S_COLLECT) && rx_valid) begin
      shadow_s[idx_r] = rx_byte;
    end else begin
      shadow_s = shadow_r;
    end
    for (int k = 0; k < 7; k++) begin
      word_s[k] = {shadow_s[2*k], shadow_s[2*k+1]};
    end
  end

  // Event decode: NACK first, then framing errors, then timeout only when nothing happened.
  always_comb begin
    fault_s  = CODE_NONE;
    commit_s = 1'b0;
    case (state_r)
      S_COLLECT: begin
        if (ack_err) begin
          fault_s = CODE_NACK;
        end else if (rx_done && !last_byte_s) begin
          fault_s = CODE_SHORT;
        end else if (rx_done) begin
          commit_s = 1'b1;
        end else if (!rx_valid && tmo_hit_s) begin
          fault_s = CODE_TMO;
        end else begin
          fault_s = CODE_NONE;
        end
      end
      S_WAIT_DONE: begin
        if (ack_err) begin
          fault_s = CODE_NACK;
        end else if (rx_valid) begin
          fault_s = CODE_OVERRUN;
        end else if (rx_done) begin
          commit_s = 1'b1;
        end else if (tmo_hit_s) begin
          fault_s = CODE_TMO;
        end else begin
          fault_s = CODE_NONE;
        end
      end
      default: begin
        fault_s  = CODE_NONE;
        commit_s = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_IDLE;
      en_start_d_r   <= 1'b0;
      idx_r          <= 4'd0;
      tmo_r          <= '0;
      sample_valid_r <= 1'b0;
      err_r          <= 1'b0;
      err_code_r     <= 3'd0;
      cnt_r          <= 16'd0;
      busy_r         <= 1'b0;
      for (int i = 0; i < 14; i++) shadow_r[i] <= 8'h00;
      for (int k = 0; k < 7; k++) word_r[k] <= 16'h0000;
    end else begin
      en_start_d_r   <= en_start;
      shadow_r       <= shadow_s;
      sample_valid_r <= 1'b0;
      err_r          <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start_s && rd_now) begin
            idx_r   <= 4'd0;
            tmo_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= S_COLLECT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_COLLECT, S_WAIT_DONE: begin
          if (fault_s != CODE_NONE) begin
            err_r      <= 1'b1;
            err_code_r <= fault_s;
            state_r    <= S_ERR;
          end else if (commit_s) begin
            word_r         <= word_s;
            sample_valid_r <= 1'b1;
            cnt_r          <= cnt_r + 16'd1;
            state_r        <= S_COMMIT;
          end else if ((state_r == S_COLLECT) && rx_valid) begin
            idx_r <= idx_r + 4'd1;
            tmo_r <= '0;
            if (last_byte_s) begin
              state_r <= S_WAIT_DONE;
            end else begin
              state_r <= S_COLLECT;
            end
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        S_COMMIT, S_ERR: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign accel_x      = word_r[0];
  assign accel_y      = word_r[1];
  assign accel_z      = word_r[2];
  assign temp         = word_r[3];
  assign gyro_x       = word_r[4];
  assign gyro_y       = word_r[5];
  assign gyro_z       = word_r[6];
  assign sample_valid = sample_valid_r;
  assign busy         = busy_r;
  assign err          = err_r;
  assign err_code     = err_code_r;
  assign sample_cnt   = cnt_r;

endmodule

// File: tb/tb_mpu_rx_unpack.sv
// Scoreboard bench for mpu_rx_unpack: stimulus queues expected commit/error events,
// a negedge monitor pops and compares them whenever sample_valid or err pulses.
module tb_mpu_rx_unpack;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_start = 1'b0;
  logic        rd_now = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_done = 1'b0;
  logic        ack_err = 1'b0;
  logic [15:0] accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z;
  logic        sample_valid, busy, err;
  logic [2:0]  err_code;
  logic [15:0] sample_cnt;

  mpu_rx_unpack #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .en_start(en_start), .rd_now(rd_now),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_done(rx_done), .ack_err(ack_err),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z), .temp(temp),
    .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .sample_valid(sample_valid), .busy(busy), .err(err), .err_code(err_code),
    .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         is_err;
    logic [2:0]   code;
    logic [111:0] w;
    logic [15:0]  cnt;
  } exp_t;

  exp_t         exp_q[$];
  logic [111:0] good_w = 112'h0;
  logic [15:0]  good_cnt = 16'd0;
  int           total = 0;
  int           bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic logic [111:0] all_words();
    return {accel_x, accel_y, accel_z, temp, gyro_x, gyro_y, gyro_z};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (sample_valid || err)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got sv=%0b err=%0b code=%0d want none", sample_valid, err, err_code);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {126'd0, sample_valid, err}, e.is_err ? 128'd1 : 128'd2);
        check("words", all_words(), e.w);
        check("sample_cnt", sample_cnt, e.cnt);
        if (e.is_err) check("err_code", err_code, e.code);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_rd();
    en_start = 1'b1; rd_now = 1'b1;
    @(negedge clk);
    en_start = 1'b0; rd_now = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic push_sample(input logic [111:0] w);
    good_w = w;
    good_cnt = good_cnt + 16'd1;
    exp_q.push_back({1'b0, 3'd0, w, good_cnt});
  endtask

  task automatic push_err(input logic [2:0] c);
    exp_q.push_back({1'b1, c, good_w, good_cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] clean [14];
    int n;
    int busy_hi;
    clean = '{8'hFE, 8'hDC, 8'h80, 8'h00, 8'h7F, 8'hFF, 8'h12,
              8'h34, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h55, 8'hAA};

    tick(2);
    check("rst_words", all_words(), 112'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_cnt", sample_cnt, 16'd0);
    check("rst_code", err_code, 3'd0);
    rst_n = 1'b1;
    tick(2);

    // Basic burst 0x01..0x0E, rx_done in a separate cycle.
    start_rd();
    for (int i = 1; i <= 14; i++) send(8'(i));
    push_sample(112'h0102_0304_0506_0708_090A_0B0C_0D0E);
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("commit_latency", sample_valid, 1'b1);
    check("busy_in_commit", busy, 1'b1);
    tick(1);
    check("busy_after_commit", busy, 1'b0);
    check("sv_one_cycle", sample_valid, 1'b0);

    // Short burst of 10 bytes.
    start_rd();
    for (int i = 0; i < 10; i++) send(8'hFF);
    push_err(3'd1);
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("short_latency", err, 1'b1);
    tick(2);

    // Held en_start never retriggers, even when rd_now later rises.
    busy_hi = 0;
    en_start = 1'b1; rd_now = 1'b0;
    repeat (20) begin @(negedge clk); if (busy) busy_hi++; end
    rd_now = 1'b1;
    repeat (20) begin @(negedge clk); if (busy) busy_hi++; end
    en_start = 1'b0; rd_now = 1'b0;
    check("held_no_start", busy_hi, 0);
    tick(2);

    // Stall after 3 bytes.
    start_rd();
    for (int i = 0; i < 3; i++) send(8'h40 + 8'(i));
    push_err(3'd4);
    n = 0;
    while (!err && n < TMO + 20) begin @(negedge clk); n++; end
    check("timeout_cycles", n, TMO);
    tick(2);

    // Extra byte after the 14th.
    start_rd();
    for (int i = 0; i < 14; i++) send(8'h20 + 8'(i));
    push_err(3'd2);
    send(8'h99);
    check("overrun_latency", err, 1'b1);
    tick(2);

    // NACK coincident with 14th byte and rx_done.
    start_rd();
    for (int i = 0; i < 13; i++) send(8'h60 + 8'(i));
    push_err(3'd3);
    rx_byte = 8'h6D; rx_valid = 1'b1; rx_done = 1'b1; ack_err = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_done = 1'b0; ack_err = 1'b0;
    check("nack_err", err, 1'b1);
    check("nack_no_sample", sample_valid, 1'b0);
    tick(2);

    // Clean burst with last byte and rx_done together.
    start_rd();
    for (int i = 0; i < 13; i++) send(clean[i]);
    push_sample(112'hFEDC_8000_7FFF_1234_0001_ABCD_55AA);
    rx_byte = clean[13]; rx_valid = 1'b1; rx_done = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_done = 1'b0;
    check("simul_commit_latency", sample_valid, 1'b1);
    tick(3);
    check("queue_drained", exp_q.size(), 0);

    // Reset mid-burst clears everything asynchronously.
    start_rd();
    for (int i = 0; i < 5; i++) send(8'h77);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_words", all_words(), 112'h0);
    check("midrst_cnt", sample_cnt, 16'd0);
    check("midrst_code", err_code, 3'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
